// File: rtl/systolic_ctrl_if.sv
// Tile-load and array-feed signal bundle for systolic_ctrl.
// master = host/DMA side driving writes and starts, slave = the sequencer.
interface systolic_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIM        = 3,
    parameter int unsigned K_MAX      = 16
);
    localparam int unsigned K_W    = $clog2(K_MAX);
    localparam int unsigned LANE_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned FEED_W = DATA_WIDTH * DIM;

    logic                  wr_en;
    logic                  wr_sel;
    logic [LANE_W-1:0]     wr_lane;
    logic [K_W-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  start;
    logic [K_W:0]          k_len;
    logic [FEED_W-1:0]     feed_1;
    logic [FEED_W-1:0]     feed_2;
    logic                  acc_clr;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [15:0]           run_count;

    modport master (
        output wr_en, wr_sel, wr_lane, wr_addr, wr_data, start, k_len,
        input  feed_1, feed_2, acc_clr, busy, done, err, run_count
    );

    modport slave (
        input  wr_en, wr_sel, wr_lane, wr_addr, wr_data, start, k_len,
        output feed_1, feed_2, acc_clr, busy, done, err, run_count
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Operand sequencer for a DIM x DIM systolic array: per-lane K-deep buffers, skewed feed, clear/drain/done.
// Optional completed-run counter enabled by defining SYSTOLIC_CTRL_RUN_COUNT_EN.
module systolic_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIM        = 3,
    parameter int unsigned K_MAX      = 16
) (
    input  logic            clk,
    input  logic            rst,
    systolic_ctrl_if.slave  bus
);
    localparam int unsigned K_W    = $clog2(K_MAX);
    localparam int unsigned LANE_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned FEED_W = DATA_WIDTH * DIM;
    localparam int unsigned CNT_W  = $clog2(K_MAX + DIM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [K_W:0]      klen_q, klen_d;
    logic [FEED_W-1:0] feed_1_q, feed_1_d;
    logic [FEED_W-1:0] feed_2_q, feed_2_d;
    logic              acc_clr_q, acc_clr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_WIDTH-1:0] down_buf  [DIM][K_MAX];
    logic [DATA_WIDTH-1:0] right_buf [DIM][K_MAX];
    logic [CNT_W-1:0]      rd_idx    [DIM];

    logic wr_ok;
    logic klen_ok;
    logic stream_last;
    logic drain_last;

    assign wr_ok = bus.wr_en && (state_q == S_IDLE)
                 && ({1'b0, bus.wr_lane} < (LANE_W + 1)'(DIM));
    assign klen_ok = (bus.k_len != '0) && (bus.k_len <= (K_W + 1)'(K_MAX));
    assign stream_last = (cnt_q + CNT_W'(1)) == (CNT_W'(klen_q) + CNT_W'(DIM - 1));
    assign drain_last  = (cnt_q == CNT_W'(DIM - 1));

    // Operand storage is deliberately not reset; only the host rewrites it.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (bus.wr_sel) right_buf[bus.wr_lane][bus.wr_addr] <= bus.wr_data;
            else            down_buf[bus.wr_lane][bus.wr_addr]  <= bus.wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        klen_d   = klen_q;
        err_d    = 1'b0;
        feed_1_d = '0;
        feed_2_d = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (klen_ok) begin
                        klen_d  = bus.k_len;
                        state_d = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (stream_last) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_last) state_d = S_DONE;
                else            cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Lane j lags by j cycles so element k meets PE[i][j] at cycle k+i+j.
        for (int unsigned j = 0; j < DIM; j++) begin
            rd_idx[j] = cnt_d - CNT_W'(j);
            if ((state_d == S_STREAM) && (cnt_d >= CNT_W'(j))
                && (rd_idx[j] < CNT_W'(klen_q))) begin
                feed_1_d[j*DATA_WIDTH +: DATA_WIDTH] = down_buf[j][rd_idx[j][K_W-1:0]];
                feed_2_d[j*DATA_WIDTH +: DATA_WIDTH] = right_buf[j][rd_idx[j][K_W-1:0]];
            end
        end

        acc_clr_d = (state_d == S_CLEAR);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            klen_q    <= '0;
            feed_1_q  <= '0;
            feed_2_q  <= '0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            klen_q    <= klen_d;
            feed_1_q  <= feed_1_d;
            feed_2_q  <= feed_2_d;
            acc_clr_q <= acc_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.feed_1  = feed_1_q;
    assign bus.feed_2  = feed_2_q;
    assign bus.acc_clr = acc_clr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

`ifdef SYSTOLIC_CTRL_RUN_COUNT_EN
    logic [15:0] run_count_q, run_count_d;

    // Counts up together with the done pulse; wraps naturally at 16 bits.
    assign run_count_d = run_count_q + 16'(done_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_count_q <= '0;
        else     run_count_q <= run_count_d;
    end

    assign bus.run_count = run_count_q;
`else
    assign bus.run_count = '0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl (DIM=3, K_MAX=16).
module tb_systolic_ctrl;
    localparam int unsigned DW     = 16;
    localparam int unsigned DIM    = 3;
    localparam int unsigned K_MAX  = 16;
    localparam int unsigned K_W    = $clog2(K_MAX);
    localparam int unsigned LANE_W = $clog2(DIM);
    localparam int unsigned FW     = DW * DIM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.DATA_WIDTH(DW), .DIM(DIM), .K_MAX(K_MAX)) bus ();

    systolic_ctrl #(.DATA_WIDTH(DW), .DIM(DIM), .K_MAX(K_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int done_n;
    int runs_since_rst = 0;
    logic [FW-1:0] cap1 [64];
    logic [FW-1:0] cap2 [64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] pack3(input int l2, input int l1, input int l0);
        return {DW'(l2), DW'(l1), DW'(l0)};
    endfunction

    function automatic logic [DW-1:0] lane(input logic [FW-1:0] v, input int j);
        return v[j*DW +: DW];
    endfunction

    task automatic wr(input logic sel, input int ln, input int addr, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_lane = LANE_W'(ln);
        bus.wr_addr = K_W'(addr);
        bus.wr_data = DW'(d);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Start a run, capture feeds from STREAM t=0 onward, and time the done pulse.
    task automatic run(input int k, input bit disturb);
        bit clr_extra;
        clr_extra = 1'b0;
        done_n    = -1;
        for (int i = 0; i < 64; i++) begin
            cap1[i] = '0;
            cap2[i] = '0;
        end
        bus.start = 1'b1;
        bus.k_len = (K_W + 1)'(k);
        tick();
        bus.start = 1'b0;
        check("acc_clr_pulse", 64'(bus.acc_clr), 64'd1);
        check("busy_in_clear", 64'(bus.busy), 64'd1);
        for (int n = 2; n < 80; n++) begin
            tick();
            cap1[n-2] = bus.feed_1;
            cap2[n-2] = bus.feed_2;
            if (bus.acc_clr) clr_extra = 1'b1;
            if (disturb && n == 3) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_lane = '0;
                bus.wr_addr = '0;
                bus.wr_data = 16'hFFFF;
                bus.start   = 1'b1;
                bus.k_len   = 5'd2;
            end
            if (disturb && n == 4) begin
                bus.wr_en = 1'b0;
                bus.start = 1'b0;
            end
            if (bus.done) begin
                done_n = n;
                runs_since_rst++;
                if (disturb) begin
                    bus.start = 1'b1;
                    bus.k_len = 5'd2;
                end
                break;
            end
        end
        check("acc_clr_single", 64'(clr_extra), 64'd0);
        check("done_latency", 64'(done_n), 64'(k + 2*DIM + 1));
        tick();
        bus.start = 1'b0;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic chk_k2_feeds();
        logic [FW-1:0] e1 [7];
        logic [FW-1:0] e2 [7];
        e1 = '{pack3(0,0,1), pack3(0,1,2), pack3(1,2,0), pack3(2,0,0), FW'(0), FW'(0), FW'(0)};
        e2 = '{pack3(0,0,3), pack3(0,3,4), pack3(3,4,0), pack3(4,0,0), FW'(0), FW'(0), FW'(0)};
        for (int t = 0; t < 7; t++) begin
            check($sformatf("feed_1_t%0d", t), 64'(cap1[t]), 64'(e1[t]));
            check($sformatf("feed_2_t%0d", t), 64'(cap2[t]), 64'(e2[t]));
        end
    endtask

    // Array model: PE[i][j] sees i_1 lane j delayed i cycles and i_2 lane i delayed j cycles.
    task automatic chk_pe(input int exp);
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                int acc;
                acc = 0;
                for (int t = 0; t < 64; t++) begin
                    if (t >= i && t >= j)
                        acc += int'(lane(cap1[t-i], j)) * int'(lane(cap2[t-j], i));
                end
                check($sformatf("pe_%0d%0d", i, j), 64'(acc), 64'(exp));
            end
        end
    endtask

    task automatic chk_run_count();
`ifdef SYSTOLIC_CTRL_RUN_COUNT_EN
        check("run_count", 64'(bus.run_count), 64'(runs_since_rst));
`else
        check("run_count", 64'(bus.run_count), 64'd0);
`endif
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_lane = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.k_len   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rst_feed_1", 64'(bus.feed_1), 64'd0);
        check("rst_feed_2", 64'(bus.feed_2), 64'd0);
        check("rst_acc_clr", 64'(bus.acc_clr), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_run_count", 64'(bus.run_count), 64'd0);

        for (int j = 0; j < DIM; j++) begin
            wr(1'b0, j, 0, 1);
            wr(1'b0, j, 1, 2);
            wr(1'b1, j, 0, 3);
            wr(1'b1, j, 1, 4);
        end
        run(2, 1'b0);
        chk_k2_feeds();
        chk_pe(11);

        // Illegal k_len values flag err and leave the sequencer idle.
        for (int s = 0; s < 2; s++) begin
            int kk;
            kk = (s == 0) ? 0 : 17;
            bus.start = 1'b1;
            bus.k_len = (K_W + 1)'(kk);
            tick();
            bus.start = 1'b0;
            check($sformatf("err_k%0d", kk), 64'(bus.err), 64'd1);
            check($sformatf("err_busy_k%0d", kk), 64'(bus.busy), 64'd0);
            check($sformatf("err_feed_k%0d", kk), 64'(bus.feed_1 | bus.feed_2), 64'd0);
            tick();
            check($sformatf("err_clear_k%0d", kk), 64'(bus.err), 64'd0);
            check($sformatf("err_idle_k%0d", kk), 64'(bus.busy), 64'd0);
        end

        // Write and start while busy, plus start alongside done: all ignored.
        run(2, 1'b1);
        chk_k2_feeds();
        run(2, 1'b0);
        chk_k2_feeds();
        chk_pe(11);

        // Write accepted in the same cycle as start is visible at t=0.
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_lane = '0;
        bus.wr_addr = '0;
        bus.wr_data = 16'd5;
        bus.start   = 1'b1;
        bus.k_len   = 5'd2;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        tick();
        check("wr_with_start_t0", 64'(bus.feed_1), 64'(pack3(0, 0, 5)));
        for (int n = 0; n < 40 && bus.busy; n++) tick();
        check("wr_with_start_idle", 64'(bus.busy), 64'd0);
        runs_since_rst++;
        wr(1'b0, 0, 0, 1);

        // Asynchronous reset at STREAM t=2.
        bus.start = 1'b1;
        bus.k_len = 5'd2;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("pre_rst_feed_1", 64'(bus.feed_1), 64'(pack3(1, 2, 0)));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_feed_1", 64'(bus.feed_1), 64'd0);
        check("rst_mid_feed_2", 64'(bus.feed_2), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        runs_since_rst = 0;
        begin
            bit seen;
            seen = 1'b0;
            repeat (15) begin
                tick();
                if (bus.done) seen = 1'b1;
            end
            check("no_done_after_rst", 64'(seen), 64'd0);
        end
        chk_run_count();
        run(2, 1'b0);
        chk_pe(11);
        run(2, 1'b0);
        run(2, 1'b0);
        chk_run_count();

        // Full-depth run: lane j carries k+1 for k = 0..15.
        for (int j = 0; j < DIM; j++)
            for (int k = 0; k < K_MAX; k++)
                wr(1'b0, j, k, k + 1);
        run(K_MAX, 1'b0);
        for (int t = 0; t < 21; t++) begin
            logic [FW-1:0] e;
            e = '0;
            for (int j = 0; j < DIM; j++)
                if (t >= j && t - j < K_MAX) e[j*DW +: DW] = DW'(t - j + 1);
            check($sformatf("kmax_feed_1_t%0d", t), 64'(cap1[t]), 64'(e));
        end
        check("kmax_lane2_last", 64'(lane(cap1[17], 2)), 64'd16);
        check("kmax_lane2_after", 64'(lane(cap1[18], 2)), 64'd0);
        chk_run_count();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
